// File: rtl/instr_register_calc_if.sv
// Bus bundle for instr_register_calc: write/read request signals driven by the
// master, stored-entry read data and occupancy returned by the slave.
interface instr_register_calc_if #(
    parameter int OP_WIDTH = 32,
    parameter int DEPTH    = 32
);
    localparam int AW = $clog2(DEPTH);

    logic                         load_en;
    logic                         clear;
    logic [2:0]                   opcode;
    logic signed [OP_WIDTH-1:0]   operand_a;
    logic signed [OP_WIDTH-1:0]   operand_b;
    logic [AW-1:0]                write_pointer;
    logic [AW-1:0]                read_pointer;
    logic                         rd_en;

    logic                         rd_valid;
    logic                         rd_entry_valid;
    logic [2:0]                   rd_opcode;
    logic signed [OP_WIDTH-1:0]   rd_operand_a;
    logic signed [OP_WIDTH-1:0]   rd_operand_b;
    logic signed [2*OP_WIDTH-1:0] rd_result;
    logic                         rd_div_err;
    logic [AW:0]                  count;
    logic                         full;

    modport master (
        output load_en, clear, opcode, operand_a, operand_b,
               write_pointer, read_pointer, rd_en,
        input  rd_valid, rd_entry_valid, rd_opcode, rd_operand_a,
               rd_operand_b, rd_result, rd_div_err, count, full
    );

    modport slave (
        input  load_en, clear, opcode, operand_a, operand_b,
               write_pointer, read_pointer, rd_en,
        output rd_valid, rd_entry_valid, rd_opcode, rd_operand_a,
               rd_operand_b, rd_result, rd_div_err, count, full
    );
endinterface

// File: rtl/instr_register_calc.sv
// Instruction register file: each write stores opcode, operands and the
// computed signed result; registered read port, per-entry valid, occupancy.
module instr_register_calc #(
    parameter int OP_WIDTH = 32,
    parameter int DEPTH    = 32,
    parameter int AUTO_INC = 0
) (
    input logic                  clk,
    input logic                  reset_n,
    instr_register_calc_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OP_WIDTH;

    logic [2:0]                 mem_op  [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_a   [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_b   [DEPTH];
    logic signed [RW-1:0]       mem_res [DEPTH];
    logic [DEPTH-1:0]           mem_valid;
    logic [DEPTH-1:0]           mem_err;

    logic [AW-1:0]              wptr;
    logic [AW-1:0]              waddr;
    logic [AW:0]                count_q;
    logic [AW:0]                cnt_next;
    logic                       full_q;

    logic                       rd_valid_q;
    logic                       rd_entry_valid_q;
    logic [2:0]                 rd_opcode_q;
    logic signed [OP_WIDTH-1:0] rd_a_q;
    logic signed [OP_WIDTH-1:0] rd_b_q;
    logic signed [RW-1:0]       rd_res_q;
    logic                       rd_err_q;

    logic signed [RW-1:0]       a_x;
    logic signed [RW-1:0]       b_x;
    logic signed [RW-1:0]       calc_result;
    logic                       calc_err;

    // Operate at double width so ADD/SUB/MULT and MIN/-1 division never overflow.
    assign a_x = {{OP_WIDTH{bus.operand_a[OP_WIDTH-1]}}, bus.operand_a};
    assign b_x = {{OP_WIDTH{bus.operand_b[OP_WIDTH-1]}}, bus.operand_b};

    always_comb begin
        calc_result = '0;
        calc_err    = 1'b0;
        case (bus.opcode)
            3'd1: calc_result = a_x;
            3'd2: calc_result = b_x;
            3'd3: calc_result = a_x + b_x;
            3'd4: calc_result = a_x - b_x;
            3'd5: calc_result = a_x * b_x;
            3'd6: begin
                if (b_x == '0) calc_err = 1'b1;
                else           calc_result = a_x / b_x;
            end
            3'd7: begin
                if (b_x == '0) calc_err = 1'b1;
                else           calc_result = a_x % b_x;
            end
            default: calc_result = '0;
        endcase
    end

    // With auto-increment, a write that coincides with clear lands in slot 0.
    generate
        if (AUTO_INC != 0) begin : g_auto
            assign waddr = bus.clear ? '0 : wptr;
        end else begin : g_addr
            assign waddr = bus.write_pointer;
        end
    endgenerate

    always_comb begin
        cnt_next = bus.clear ? '0 : count_q;
        if (bus.load_en && (bus.clear || !mem_valid[waddr]))
            cnt_next = cnt_next + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_op[i]  <= '0;
                mem_a[i]   <= '0;
                mem_b[i]   <= '0;
                mem_res[i] <= '0;
            end
            mem_valid        <= '0;
            mem_err          <= '0;
            wptr             <= '0;
            count_q          <= '0;
            full_q           <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_entry_valid_q <= 1'b0;
            rd_opcode_q      <= '0;
            rd_a_q           <= '0;
            rd_b_q           <= '0;
            rd_res_q         <= '0;
            rd_err_q         <= 1'b0;
        end else begin
            // Reads sample pre-edge contents, giving read-before-write.
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_entry_valid_q <= mem_valid[bus.read_pointer];
                rd_opcode_q      <= mem_op[bus.read_pointer];
                rd_a_q           <= mem_a[bus.read_pointer];
                rd_b_q           <= mem_b[bus.read_pointer];
                rd_res_q         <= mem_res[bus.read_pointer];
                rd_err_q         <= mem_err[bus.read_pointer];
            end

            if (bus.clear) begin
                mem_valid <= '0;
                wptr      <= '0;
            end

            if (bus.load_en) begin
                mem_op[waddr]    <= bus.opcode;
                mem_a[waddr]     <= bus.operand_a;
                mem_b[waddr]     <= bus.operand_b;
                mem_res[waddr]   <= calc_result;
                mem_err[waddr]   <= calc_err;
                mem_valid[waddr] <= 1'b1;
                if (AUTO_INC != 0) wptr <= waddr + AW'(1);
            end

            count_q <= cnt_next;
            full_q  <= (cnt_next == (AW+1)'(DEPTH));
        end
    end

    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_entry_valid = rd_entry_valid_q;
    assign bus.rd_opcode      = rd_opcode_q;
    assign bus.rd_operand_a   = rd_a_q;
    assign bus.rd_operand_b   = rd_b_q;
    assign bus.rd_result      = rd_res_q;
    assign bus.rd_div_err     = rd_err_q;
    assign bus.count          = count_q;
    assign bus.full           = full_q;
endmodule

// File: tb/tb_instr_register_calc.sv
// Directed bench for instr_register_calc: addressed 32-bit instance plus an
// auto-increment DEPTH=4 instance, with hand-computed expected values.
module tb_instr_register_calc;
    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    instr_register_calc_if #(.OP_WIDTH(32), .DEPTH(32)) bus0 ();
    instr_register_calc_if #(.OP_WIDTH(8),  .DEPTH(4))  bus1 ();

    instr_register_calc #(.OP_WIDTH(32), .DEPTH(32), .AUTO_INC(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    instr_register_calc #(.OP_WIDTH(8), .DEPTH(4), .AUTO_INC(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] addr);
        bus0.load_en       = 1'b1;
        bus0.opcode        = op;
        bus0.operand_a     = a;
        bus0.operand_b     = b;
        bus0.write_pointer = addr;
        @(posedge clk); #1;
        bus0.load_en = 1'b0;
    endtask

    task automatic rd0(input logic [4:0] addr);
        bus0.rd_en        = 1'b1;
        bus0.read_pointer = addr;
        @(posedge clk); #1;
        bus0.rd_en = 1'b0;
    endtask

    logic [2:0]  t_op  [7];
    logic [31:0] t_a   [7];
    logic [31:0] t_b   [7];
    logic [63:0] t_res [7];
    logic        t_err [7];

    initial begin
        t_op[0] = 3'd5; t_a[0] = -32'sd3;      t_b[0] = 32'sd7;  t_res[0] = 64'hFFFF_FFFF_FFFF_FFEB; t_err[0] = 1'b0;
        t_op[1] = 3'd6; t_a[1] = -32'sd7;      t_b[1] = 32'sd2;  t_res[1] = 64'hFFFF_FFFF_FFFF_FFFD; t_err[1] = 1'b0;
        t_op[2] = 3'd7; t_a[2] = -32'sd7;      t_b[2] = 32'sd2;  t_res[2] = 64'hFFFF_FFFF_FFFF_FFFF; t_err[2] = 1'b0;
        t_op[3] = 3'd6; t_a[3] = 32'sd9;       t_b[3] = 32'sd0;  t_res[3] = 64'h0;                   t_err[3] = 1'b1;
        t_op[4] = 3'd4; t_a[4] = 32'h8000_0000; t_b[4] = 32'sd1; t_res[4] = 64'hFFFF_FFFF_7FFF_FFFF; t_err[4] = 1'b0;
        t_op[5] = 3'd6; t_a[5] = 32'h8000_0000; t_b[5] = -32'sd1; t_res[5] = 64'h0000_0000_8000_0000; t_err[5] = 1'b0;
        t_op[6] = 3'd7; t_a[6] = 32'sd5;       t_b[6] = 32'sd0;  t_res[6] = 64'h0;                   t_err[6] = 1'b1;

        reset_n = 1'b0;
        bus0.load_en = 0; bus0.clear = 0; bus0.opcode = 0; bus0.operand_a = 0; bus0.operand_b = 0;
        bus0.write_pointer = 0; bus0.read_pointer = 0; bus0.rd_en = 0;
        bus1.load_en = 0; bus1.clear = 0; bus1.opcode = 0; bus1.operand_a = 0; bus1.operand_b = 0;
        bus1.write_pointer = 0; bus1.read_pointer = 0; bus1.rd_en = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // reset state and read of an unwritten entry
        check_val("rst_count", 64'(bus0.count), 64'd0);
        check_val("rst_full", 64'(bus0.full), 64'd0);
        check_val("rst_rd_valid", 64'(bus0.rd_valid), 64'd0);
        rd0(5);
        check_val("rd5_valid", 64'(bus0.rd_valid), 64'd1);
        check_val("rd5_entry_valid", 64'(bus0.rd_entry_valid), 64'd0);
        check_val("rd5_opcode", 64'(bus0.rd_opcode), 64'd0);
        check_val("rd5_result", bus0.rd_result, 64'd0);
        check_val("rd5_a", 64'(bus0.rd_operand_a), 64'd0);
        check_val("rd5_err", 64'(bus0.rd_div_err), 64'd0);
        @(posedge clk); #1;
        check_val("rd_valid_pulse", 64'(bus0.rd_valid), 64'd0);

        // ADD at the positive limit widens rather than wrapping
        wr0(3'd3, 32'h7FFF_FFFF, 32'd1, 5'd3);
        check_val("add_count", 64'(bus0.count), 64'd1);
        rd0(3);
        check_val("add_result", bus0.rd_result, 64'h0000_0000_8000_0000);
        check_val("add_opcode", 64'(bus0.rd_opcode), 64'd3);
        check_val("add_entry_valid", 64'(bus0.rd_entry_valid), 64'd1);
        check_val("add_a", 64'(bus0.rd_operand_a), 64'h0000_0000_7FFF_FFFF);

        // arithmetic table, then back-to-back readback
        for (int i = 0; i < 7; i++) wr0(t_op[i], t_a[i], t_b[i], 5'(i));
        check_val("arith_count", 64'(bus0.count), 64'd7);
        bus0.rd_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus0.read_pointer = 5'(i);
            @(posedge clk); #1;
            check_val($sformatf("b2b_valid_%0d", i), 64'(bus0.rd_valid), 64'd1);
            check_val($sformatf("arith_res_%0d", i), bus0.rd_result, t_res[i]);
            check_val($sformatf("arith_err_%0d", i), 64'(bus0.rd_div_err), 64'(t_err[i]));
            check_val($sformatf("arith_op_%0d", i), 64'(bus0.rd_opcode), 64'(t_op[i]));
        end
        bus0.rd_en = 1'b0;

        // same-cycle write and read of one address
        wr0(3'd1, 32'd4, 32'd0, 5'd2);
        bus0.load_en = 1'b1; bus0.opcode = 3'd2; bus0.operand_a = 0; bus0.operand_b = 32'd9;
        bus0.write_pointer = 5'd2;
        bus0.rd_en = 1'b1; bus0.read_pointer = 5'd2;
        @(posedge clk); #1;
        bus0.load_en = 1'b0; bus0.rd_en = 1'b0;
        check_val("rbw_old_result", bus0.rd_result, 64'd4);
        check_val("rbw_old_opcode", 64'(bus0.rd_opcode), 64'd1);
        rd0(2);
        check_val("rbw_new_result", bus0.rd_result, 64'd9);
        check_val("rbw_new_opcode", 64'(bus0.rd_opcode), 64'd2);
        check_val("rbw_count", 64'(bus0.count), 64'd7);

        // auto-increment instance: wraps and overwrites slot 0 when full
        bus1.write_pointer = 2'd3;
        for (int i = 0; i < 5; i++) begin
            bus1.load_en = 1'b1; bus1.opcode = 3'd1; bus1.operand_a = 8'(10 + i);
            @(posedge clk); #1;
            if (i == 2) begin
                check_val("ai_full_3", 64'(bus1.full), 64'd0);
                check_val("ai_count_3", 64'(bus1.count), 64'd3);
            end
            if (i == 3) begin
                check_val("ai_full_4", 64'(bus1.full), 64'd1);
                check_val("ai_count_4", 64'(bus1.count), 64'd4);
            end
        end
        bus1.load_en = 1'b0;
        check_val("ai_count_5", 64'(bus1.count), 64'd4);
        check_val("ai_full_5", 64'(bus1.full), 64'd1);
        bus1.rd_en = 1'b1; bus1.read_pointer = 2'd0;
        @(posedge clk); #1;
        check_val("ai_slot0", 64'(bus1.rd_result), 64'd14);
        bus1.read_pointer = 2'd1;
        @(posedge clk); #1;
        check_val("ai_slot1", 64'(bus1.rd_result), 64'd11);
        bus1.rd_en = 1'b0;

        // asynchronous reset in the middle of a write burst
        bus0.load_en = 1'b1; bus0.opcode = 3'd1; bus0.operand_a = 32'd55; bus0.write_pointer = 5'd0;
        @(posedge clk); #1;
        bus0.write_pointer = 5'd8;
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_count", 64'(bus0.count), 64'd0);
        check_val("arst_full1", 64'(bus1.full), 64'd0);
        check_val("arst_rd_result", bus0.rd_result, 64'd0);
        @(posedge clk); #1;
        bus0.load_en = 1'b0;
        reset_n = 1'b1;
        rd0(0);
        check_val("arst_entry_valid", 64'(bus0.rd_entry_valid), 64'd0);
        check_val("arst_entry_data", bus0.rd_result, 64'd0);
        check_val("arst_count_after", 64'(bus0.count), 64'd0);

        // clear together with a write
        wr0(3'd1, 32'd21, 32'd0, 5'd0);
        wr0(3'd1, 32'd22, 32'd0, 5'd1);
        check_val("pre_clear_count", 64'(bus0.count), 64'd2);
        bus0.clear = 1'b1;
        wr0(3'd1, 32'd5, 32'd0, 5'd7);
        bus0.clear = 1'b0;
        check_val("clear_wr_count", 64'(bus0.count), 64'd1);
        check_val("clear_wr_full", 64'(bus0.full), 64'd0);
        rd0(0);
        check_val("clear_slot0_valid", 64'(bus0.rd_entry_valid), 64'd0);
        check_val("clear_slot0_data", bus0.rd_result, 64'd21);
        rd0(7);
        check_val("clear_slot7_valid", 64'(bus0.rd_entry_valid), 64'd1);
        check_val("clear_slot7_data", bus0.rd_result, 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_register_calc.md
Name: instr_register_calc

Overview:
Parametrised successor to the lab instruction register. It stores DEPTH instruction words, each holding an opcode and two signed operands, and computes and stores the result when the word is written. It adds a registered read port with a valid strobe, per-entry valid bits, an occupancy count, divide-by-zero flagging and an optional auto-increment write mode. It sits behind the testbench interface as the DUT.

Parameters:
OP_WIDTH, 32, signed operand width in bits (min 4)
DEPTH, 32, number of entries (power of 2, min 2)
AUTO_INC, 0, 1 = internal write pointer increments on each write and write_pointer is ignored; 0 = write_pointer addresses the entry
AW, $clog2(DEPTH), pointer width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
load_en  in  1  write strobe
clear  in  1  synchronous clear of all valid bits
opcode  in  3  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
operand_a  in  OP_WIDTH  signed operand A
operand_b  in  OP_WIDTH  signed operand B
write_pointer  in  AW  write address (used only when AUTO_INC=0)
read_pointer  in  AW  read address
rd_en  in  1  read strobe
rd_valid  out  1  one-cycle pulse: read data is updated
rd_entry_valid  out  1  the entry read had been written since the last clear or reset
rd_opcode  out  3  stored opcode
rd_operand_a  out  OP_WIDTH  stored operand A
rd_operand_b  out  OP_WIDTH  stored operand B
rd_result  out  2*OP_WIDTH  stored signed result
rd_div_err  out  1  stored divide-by-zero flag
count  out  AW+1  number of valid entries
full  out  1  count == DEPTH

Behaviour:
- Reset (reset_n low, asynchronous, including mid-operation):
  - All entries become opcode 0, operands 0, result 0, valid 0, div_err 0.
  - Internal write pointer = 0.
  - All rd_* outputs = 0, rd_valid = 0, count = 0, full = 0.
  - No writes or reads are accepted while reset_n is low.
- Write, on the clk edge with load_en=1:
  - Target address = write_pointer (AUTO_INC=0) or the internal pointer (AUTO_INC=1).
  - The entry captures opcode, operand_a, operand_b, the result computed combinationally from the same inputs, and div_err; its valid bit is set.
  - count increments only if the entry was previously invalid. Overwriting a valid entry leaves count unchanged.
  - AUTO_INC=1: the internal pointer increments after each write and wraps DEPTH-1 -> 0. Writes are still accepted when full; they overwrite the oldest slot.
- Arithmetic (operands signed, results sign-extended to 2*OP_WIDTH):
  - ZERO -> 0; PASSA -> a; PASSB -> b.
  - ADD -> a+b and SUB -> a-b, computed at full width with no overflow.
  - MULT -> full signed product.
  - DIV -> truncated toward zero.
  - MOD -> remainder with the sign of the dividend.
  - DIV or MOD with b=0 -> result 0 and div_err=1. div_err=0 for every other case.
- Read:
  - rd_en=1 at an edge: on the next edge the rd_* outputs load entry[read_pointer] and rd_valid pulses high for 1 cycle (latency 1).
  - The outputs hold their value until the next accepted read.
  - Reading an invalid entry returns its stored contents (zeros after reset) with rd_entry_valid=0.
- Simultaneous write and read to the same address in one cycle: the read returns the pre-write contents (read-before-write).
- clear=1 at an edge:
  - All valid bits and count go to 0; the internal pointer goes to 0. Data fields are retained.
  - If load_en is also 1, the write is applied after the clear, so count = 1 afterwards.
- Back-to-back rd_en on consecutive cycles gives rd_valid high on consecutive cycles, one entry per cycle.
- The outputs full and count are registered, with no combinational path from inputs.

Test Plan:
1. Reset, then rd_en at address 5 -> next cycle rd_valid=1, rd_entry_valid=0, all fields 0; count=0, full=0.
2. Write (OP_WIDTH=32) ADD a=0x7FFFFFFF b=1 at address 3, then read address 3 -> rd_result=0x0000_0000_8000_0000, rd_opcode=3, rd_entry_valid=1, count=1.
3. Write MULT a=-3 b=7, DIV a=-7 b=2, MOD a=-7 b=2, DIV a=9 b=0 at addresses 0..3, then read them back -> results -21, -3, -1, 0; rd_div_err is 1 only for address 3.
4. AUTO_INC=1, DEPTH=4: 5 consecutive writes with PASSA a=10..14 -> full=1 after the 4th write; address 0 holds 14 after the 5th; count stays 4.
5. Same-cycle write PASSB b=9 and read at address 2 (previously holding 4) -> read returns 4; the following read returns 9.
6. Assert reset_n low mid-burst with writes in flight, then release and read address 0 -> rd_entry_valid=0, count=0. Separately, clear together with load_en -> count=1.
